// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the alu_ctrl slice: opcodes, instruction
// field positions, ALU operation type and controller FSM states.
package alu_ctrl_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 9;
    localparam int IMM_SEL = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_LDI;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake and retirement bus between a
// requester (master) and the alu_ctrl block (slave).
interface alu_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        done;
    logic [7:0]  result;
    logic        zero_flag;
    logic        illegal;

    modport master (
        output in_valid,
        output instr,
        input  in_ready,
        input  done,
        input  result,
        input  zero_flag,
        input  illegal
    );

    modport slave (
        input  in_valid,
        input  instr,
        output in_ready,
        output done,
        output result,
        output zero_flag,
        output illegal
    );

endinterface

// File: rtl/alu_ctrl_alu.sv
// 8-bit combinational ALU: add, sub, and, or (mod 256, no carry)
// with a zero indication on the result.
module alu_ctrl_alu
    import alu_ctrl_pkg::*;
(
    input  alu_op_e    op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o,
    output logic       zero_o
);

    always_comb begin
        y_o = 8'h00;
        unique case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
        endcase
    end

    assign zero_o = (y_o == 8'h00);

endmodule

// File: rtl/alu_ctrl.sv
// Three-state (IDLE/EXEC/WB) controller around a 4x8 register file
// and the shared ALU; one instruction retires every three cycles.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);

    state_e      state_q;
    logic [15:0] instr_q;
    logic [7:0]  hold_y_q;
    logic        hold_z_q;
    logic [7:0]  regs_q [4];
    logic [7:0]  result_q;
    logic        zero_q;
    logic        done_q;
    logic        illegal_q;

    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        is_ldi;
    alu_op_e     alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_y;
    logic        alu_zero;

    assign op      = instr_q[OP_MSB:OP_LSB];
    assign rd      = instr_q[RD_MSB:RD_LSB];
    assign rs      = instr_q[RS_MSB:RS_LSB];
    assign imm_sel = instr_q[IMM_SEL];
    assign imm     = instr_q[IMM_MSB:IMM_LSB];
    assign is_ldi  = (op == OP_LDI);

    // LDI rides the ALU as 0 | imm so its zero flag comes for free
    assign alu_op = is_ldi ? ALU_OR : alu_op_e'(op[1:0]);
    assign alu_a  = is_ldi ? 8'h00 : regs_q[rd];
    assign alu_b  = (is_ldi || imm_sel) ? imm : regs_q[rs];

    alu_ctrl_alu u_alu (
        .op_i   (alu_op),
        .a_i    (alu_a),
        .b_i    (alu_b),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= 16'h0000;
            hold_y_q  <= 8'h00;
            hold_z_q  <= 1'b0;
            result_q  <= 8'h00;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= REG_INIT;
            end
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        instr_q <= bus.instr;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    hold_y_q <= alu_y;
                    hold_z_q <= alu_zero;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                    if (op_legal(op)) begin
                        regs_q[rd] <= hold_y_q;
                        result_q   <= hold_y_q;
                        zero_q     <= hold_z_q;
                    end else begin
                        illegal_q <= 1'b1;
                        result_q  <= 8'h00;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.zero_flag = zero_q;
    assign bus.illegal   = illegal_q;
    assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: REG_INIT, 8'h00, reset value of every register-file entry.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instruction present on instr.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 instr  input  16  [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm.
REQ-007 done  output  1  one-cycle pulse, instruction retired.
REQ-008 result  output  8  value written to R[rd], valid while done=1.
REQ-009 zero_flag  output  1  registered zero of last retired ALU/LDI result.
REQ-010 illegal  output  1  one-cycle pulse with done for an unsupported op.
REQ-011 dbg_addr  input  2  register-file read address.
REQ-012 dbg_data  output  8  combinational R[dbg_addr].

Function
REQ-013 Register file: 4 entries x 8 bits, one write port, combinational reads.
REQ-014 FSM states IDLE, EXEC, WB; reset state IDLE.
REQ-015 in_ready=1 only in IDLE; accept on in_valid&in_ready at an edge: latch instr, go to EXEC.
REQ-016 IDLE with in_valid=0 remains IDLE; instr is ignored outside an accepting edge.
REQ-017 EXEC: drive ALU with op=instr[15:13], a=R[rd], b=imm_sel ? imm : R[rs]; capture y and zero into holding registers; go to WB.
REQ-018 ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, all mod 2^8 with no carry or borrow output.
REQ-019 Op 100 LDI: captured value = imm regardless of imm_sel; zero = (imm==0).
REQ-020 Ops 101, 110, 111 are illegal: no register write and zero_flag unchanged.
REQ-021 WB: write the captured value to R[rd] (legal ops only); update zero_flag; pulse done for one cycle; return to IDLE.
REQ-022 For an illegal op, WB pulses illegal together with done, and result = 8'h00.
REQ-023 result is held from the last retirement between done pulses.
REQ-024 Latency: accept at edge N, done high during cycle N+2. Maximum throughput: one instruction per 3 cycles.
REQ-025 rd==rs uses the pre-write value of R[rd] as both operands.
REQ-026 A write to R[dbg_addr] is visible on dbg_data the cycle after the WB edge.

Reset
REQ-027 While rst_n=0: state=IDLE, in_ready=1, done=0, illegal=0, result=8'h00, zero_flag=0, all registers=REG_INIT.
REQ-028 Reset asserted in EXEC or WB aborts the instruction: no write, no done.
REQ-029 After rst_n deasserts, an instruction can be accepted at the first edge.

Structure
REQ-030 Shared package holds the op encodings (ADD, SUB, AND, OR, LDI), the FSM state type, and the instr field positions.
REQ-031 The existing 8-bit ALU is instantiated as a sub-module named u_alu, and no arithmetic is duplicated in alu_ctrl.
REQ-032 Control logic and the register file live in alu_ctrl, with no further sub-modules.

Verification
REQ-033 Reset, then LDI rd=0 imm=8'h05 -> done at N+2, result=05, R0=05, zero_flag=0, in_ready=0 during EXEC and WB.
REQ-034 R0=05, then SUB rd=0 imm_sel=1 imm=05 -> result=00, zero_flag=1, R0=00.
REQ-035 R1=FF, R2=02, then ADD rd=1 rs=2 -> result=01 (wrap-around), zero_flag=0.
REQ-036 R3=A5, then AND rd=3 rs=3 -> result=A5; then OR rd=3 imm_sel=1 imm=5A -> result=FF.
REQ-037 op=110 -> done and illegal both pulse, result=00, all registers and zero_flag unchanged.
REQ-038 Hold in_valid=1 with back-to-back instructions -> accepts only in IDLE, done every 3 cycles; a reset pulse mid-EXEC -> no write, no done, state IDLE.
